// File: rtl/inst_encoder_if.sv
// ============================================================================
// Module   : inst_encoder_if
// Brief    : Field-tuple valid/ready stream feeding the instruction encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inst_encoder_if #(
  parameter int M_WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [3:0]         reg0;
  logic [3:0]         reg1;
  logic [3:0]         reg2;
  logic               use_imm;
  logic [M_WIDTH-1:0] imm;

  modport master (
    output in_valid, op, reg0, reg1, reg2, use_imm, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, reg0, reg1, reg2, use_imm, imm,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// Module   : inst_encoder
// Brief    : Packs decoded field tuples into instruction words and loads them
//            into consecutive instruction-memory addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_encoder #(
  parameter int         M_WIDTH    = 8,
  parameter int         INST_WIDTH = 16,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [3:0] OP_JMP     = 4'b0000,
  parameter logic [3:0] OP_LODI    = 4'b0101
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [ADDR_WIDTH-1:0] base_addr,
  input  wire logic [ADDR_WIDTH:0]   len,
  inst_encoder_if.slave              s_in,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [INST_WIDTH-1:0]      mem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_WIDTH-1:0]      err_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [INST_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  state_t                w_nxt_state;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [ADDR_WIDTH:0]   w_nxt_count;
  logic                  w_nxt_we;
  logic [ADDR_WIDTH-1:0] w_nxt_maddr;
  logic [INST_WIDTH-1:0] w_nxt_wdata;
  logic                  w_nxt_done;
  logic                  w_nxt_err;
  logic [ADDR_WIDTH-1:0] w_nxt_err_addr;

  logic                  w_in_ready;
  logic                  w_hs;
  logic                  w_wide;
  logic [M_WIDTH-4:0]    w_imm_hi;
  logic                  w_range_err;
  logic [INST_WIDTH-1:0] w_word;

  assign w_in_ready     = (r_state == S_LOAD) && !start;
  assign s_in.in_ready  = w_in_ready;
  assign w_hs           = s_in.in_valid && w_in_ready;

  // Short immediates must sign-extend from bit 3, so the upper bits must agree.
  assign w_wide      = (s_in.op == OP_LODI) || (s_in.op == OP_JMP);
  assign w_imm_hi    = s_in.imm[M_WIDTH-1:3];
  assign w_range_err = !w_wide && s_in.use_imm && !((&w_imm_hi) || (~|w_imm_hi));

  always_comb begin
    w_word = {s_in.op, s_in.reg0, s_in.reg1, s_in.reg2};
    if (w_wide) begin
      w_word = {s_in.op, s_in.reg0, s_in.imm[7:0]};
    end else if (s_in.use_imm) begin
      w_word = {s_in.op, s_in.reg0, s_in.reg1, s_in.imm[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_maddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_addr     <= w_nxt_addr;
      r_count    <= w_nxt_count;
      r_we       <= w_nxt_we;
      r_maddr    <= w_nxt_maddr;
      r_wdata    <= w_nxt_wdata;
      r_busy     <= (w_nxt_state == S_LOAD);
      r_done     <= w_nxt_done;
      r_err      <= w_nxt_err;
      r_err_addr <= w_nxt_err_addr;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_addr     = r_addr;
    w_nxt_count    = r_count;
    w_nxt_we       = 1'b0;
    w_nxt_maddr    = r_maddr;
    w_nxt_wdata    = r_wdata;
    w_nxt_done     = 1'b0;
    w_nxt_err      = r_err;
    w_nxt_err_addr = r_err_addr;

    // start aborts whatever is in flight and restarts from IDLE semantics.
    if (start) begin
      w_nxt_addr     = base_addr;
      w_nxt_count    = len;
      w_nxt_err      = 1'b0;
      w_nxt_err_addr = '0;
      if (len == '0) begin
        w_nxt_state = S_IDLE;
        w_nxt_done  = 1'b1;
      end else begin
        w_nxt_state = S_LOAD;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_hs) begin
            if (w_range_err) begin
              w_nxt_state    = S_ERR;
              w_nxt_err      = 1'b1;
              w_nxt_err_addr = r_addr;
            end else begin
              w_nxt_we    = 1'b1;
              w_nxt_maddr = r_addr;
              w_nxt_wdata = w_word;
              w_nxt_addr  = r_addr + 1'b1;
              w_nxt_count = r_count - 1'b1;
              if (r_count == (ADDR_WIDTH+1)'(1)) begin
                w_nxt_state = S_IDLE;
                w_nxt_done  = 1'b1;
              end
            end
          end
        end
        S_IDLE, S_ERR: begin
          w_nxt_state = r_state;
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_addr  = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module   : tb_inst_encoder
// Brief    : Scoreboard bench for inst_encoder using directed field tuples.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] len = '0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        dn;
  } exp_t;

  exp_t q[$];

  inst_encoder_if #(.M_WIDTH(8)) bus ();

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .s_in      (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe or done pulse must match the next queued event.
  always @(negedge clk) begin
    if (rst_n && (mem_we || done)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: we=%0b addr=%h data=%h done=%0b, queue empty",
                 mem_we, mem_addr, mem_wdata, done);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (mem_we !== e.we || done !== e.dn ||
            (e.we && (mem_addr !== e.addr || mem_wdata !== e.data))) begin
          n_errors++;
          $display("FAIL write_event: got we=%0b addr=%h data=%h done=%0b, want we=%0b addr=%h data=%h done=%0b",
                   mem_we, mem_addr, mem_wdata, done, e.we, e.addr, e.data, e.dn);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op_i, input logic [3:0] r0, input logic [3:0] r1,
                      input logic [3:0] r2, input logic ui, input logic [7:0] im,
                      input bit exp_wr, input logic [7:0] ea, input logic [15:0] ed,
                      input logic edn);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.op = op_i;
    bus.reg0 = r0;
    bus.reg1 = r1;
    bus.reg2 = r2;
    bus.use_imm = ui;
    bus.imm = im;
    #0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, want 1", bus.in_ready, n);
    end else if (exp_wr) begin
      q.push_back('{we: 1'b1, addr: ea, data: ed, dn: edn});
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.reg0 = '0;
    bus.reg1 = '0;
    bus.reg2 = '0;
    bus.use_imm = 1'b0;
    bus.imm = '0;

    #12;
    chk("reset_outputs", {mem_we, busy, done, err, bus.in_ready, mem_addr, err_addr}, '0);
    chk("reset_wdata", {16'h0, mem_wdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back mixed formats
    do_start(8'h10, 9'd3);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    send(4'h5, 4'h2, 4'h0, 4'h0, 1'b0, 8'hA5, 1, 8'h10, 16'h52A5, 1'b0);
    send(4'h1, 4'h1, 4'h2, 4'h3, 1'b0, 8'h00, 1, 8'h11, 16'h1123, 1'b0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 8'h40, 1, 8'h12, 16'h0040, 1'b1);
    tick();
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    chk("queue_drained_t1", q.size(), 0);

    // Short immediate in range, then out of range
    do_start(8'h20, 9'd2);
    send(4'h3, 4'h4, 4'h5, 4'h0, 1'b1, 8'hFD, 1, 8'h20, 16'h345D, 1'b0);
    send(4'h3, 4'h4, 4'h5, 4'h0, 1'b1, 8'h08, 0, 8'h00, 16'h0000, 1'b0);
    chk("err_set", {31'h0, err}, 32'h1);
    chk("err_addr", {24'h0, err_addr}, 32'h21);
    chk("err_no_write", {31'h0, mem_we}, 32'h0);
    chk("err_in_ready", {31'h0, bus.in_ready}, 32'h0);
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("err_stays_blocked", {30'h0, bus.in_ready, err}, 32'h1);
    bus.in_valid = 1'b0;

    // Address wrap, and start clears the error
    do_start(8'hFE, 9'd3);
    chk("err_cleared_by_start", {23'h0, err, err_addr}, 32'h0);
    send(4'h2, 4'h1, 4'h2, 4'h3, 1'b0, 8'h00, 1, 8'hFE, 16'h2123, 1'b0);
    send(4'h6, 4'h7, 4'h8, 4'h0, 1'b1, 8'hF9, 1, 8'hFF, 16'h6789, 1'b0);
    send(4'h5, 4'h3, 4'h0, 4'h0, 1'b0, 8'h00, 1, 8'h00, 16'h5300, 1'b1);
    tick();

    // Zero-length session
    q.push_back('{we: 1'b0, addr: 8'h00, data: 16'h0000, dn: 1'b1});
    do_start(8'h33, 9'd0);
    chk("len0_busy", {31'h0, busy}, 32'h0);
    tick();
    tick();
    chk("queue_drained_len0", q.size(), 0);

    // Abort with a restart while a tuple is offered
    do_start(8'h40, 9'd4);
    send(4'h5, 4'h1, 4'h0, 4'h0, 1'b0, 8'h11, 1, 8'h40, 16'h5111, 1'b0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h22, 1, 8'h41, 16'h0022, 1'b0);
    start = 1'b1;
    base_addr = 8'h80;
    len = 9'd1;
    bus.in_valid = 1'b1;
    bus.op = 4'h7;
    bus.reg0 = 4'h7;
    bus.reg1 = 4'h7;
    bus.reg2 = 4'h7;
    bus.use_imm = 1'b0;
    #1;
    chk("in_ready_blocked_by_start", {31'h0, bus.in_ready}, 32'h0);
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    send(4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 8'h00, 1, 8'h80, 16'hABCD, 1'b1);
    tick();
    chk("queue_drained_abort", q.size(), 0);

    // Asynchronous reset with a write pending
    do_start(8'h50, 9'd4);
    send(4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 8'h00, 1, 8'h50, 16'h1111, 1'b0);
    bus.in_valid = 1'b1;
    bus.op = 4'h4;
    bus.reg0 = 4'h4;
    bus.reg1 = 4'h4;
    bus.reg2 = 4'h4;
    @(posedge clk);
    #1;
    chk("pending_write", {7'h0, mem_we, mem_addr, mem_wdata}, {7'h0, 1'b1, 8'h51, 16'h4444});
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {mem_we, busy, done, err, bus.in_ready, mem_addr, err_addr}, '0);
    chk("async_reset_wdata", {16'h0, mem_wdata}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_reset_idle", {29'h0, bus.in_ready, mem_we, busy}, 32'h0);
    bus.in_valid = 1'b0;

    chk("queue_empty_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
